// File: rtl/cardinal_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cardinal_pkg
//  Description : Shared definitions for the Cardinal run monitor: controller
//                state encoding, default halt instruction and the index-width
//                helper used to size node/address/counter fields.
//  Revision    : 1.0 - initial release
// ============================================================================
package cardinal_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_FLUSH = 3'd2,
        ST_DUMP  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [31:0] HALT_INSTR_DEFAULT = 32'h0000_0000;

    // Bits needed to index n items; a single item still gets a 1-bit field.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 32'd1) ? 32'd1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/cardinal_dump_seq.sv
`default_nettype none
// ============================================================================
//  Module      : cardinal_dump_seq
//  Description : Node/address beat sequencer for the post-run memory dump.
//                start_i arms the sequencer at (0,0); each valid/ready
//                handshake advances addr, wrapping into the next node.
//                done_o pulses on the handshake of the final beat.
//  Ports       : clk_i, rst_ni        - clock, async active-low reset
//                start_i              - begin a dump at node 0, addr 0
//                ready_i              - consumer accepts the current beat
//                valid_o/node_o/addr_o/last_o - current beat
//                done_o               - final beat handshaked this cycle
//  Revision    : 1.0 - initial release
// ============================================================================
module cardinal_dump_seq #(
    parameter int unsigned NUM_NODES  = 4,
    parameter int unsigned DUMP_DEPTH = 128,
    parameter int unsigned NODE_W     = 2,
    parameter int unsigned ADDR_W     = 7
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic              ready_i,
    output logic              valid_o,
    output logic [NODE_W-1:0] node_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic              last_o,
    output logic              done_o
);

    localparam logic [NODE_W-1:0] C_NODE_LAST = NODE_W'(NUM_NODES - 1);
    localparam logic [ADDR_W-1:0] C_ADDR_LAST = ADDR_W'(DUMP_DEPTH - 1);

    logic              active_q, active_d;
    logic [NODE_W-1:0] node_q, node_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              w_addr_last;
    logic              w_last;
    logic              w_fire;

    assign w_addr_last = (addr_q == C_ADDR_LAST);
    assign w_last      = active_q && (node_q == C_NODE_LAST) && w_addr_last;
    assign w_fire      = active_q && ready_i;

    // Pointers only move on a handshake, so they hold while the consumer
    // stalls; they return to (0,0) after the final beat.
    always_comb begin
        active_d = active_q;
        node_d   = node_q;
        addr_d   = addr_q;
        if (start_i) begin
            active_d = 1'b1;
            node_d   = '0;
            addr_d   = '0;
        end else if (w_fire) begin
            if (w_last) begin
                active_d = 1'b0;
                node_d   = '0;
                addr_d   = '0;
            end else if (w_addr_last) begin
                addr_d = '0;
                node_d = node_q + NODE_W'(1);
            end else begin
                addr_d = addr_q + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            active_q <= 1'b0;
            node_q   <= '0;
            addr_q   <= '0;
        end else begin
            active_q <= active_d;
            node_q   <= node_d;
            addr_q   <= addr_d;
        end
    end

    assign valid_o = active_q;
    assign node_o  = node_q;
    assign addr_o  = addr_q;
    assign last_o  = w_last;
    assign done_o  = w_fire && w_last;

endmodule
`default_nettype wire

// File: rtl/cardinal_run_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : cardinal_run_monitor
//  Description : Multi-node run-control and completion monitor. Detects the
//                halt word per node, records each node's halt cycle, then
//                flushes for FLUSH_CYCLES and streams a (node, addr) dump.
//                A run that does not fully halt within TIMEOUT_CYCLES ends
//                in DONE with timeout_o set and no dump.
//  Ports       : clk_i, rst_ni                 - clock, async active-low reset
//                run_start_i                   - start pulse (IDLE/DONE only)
//                node_fetch_en_i/node_instr_i  - per-node fetch stream
//                node_halted_o/node_cycles_o   - halt flags / halt cycles
//                cycle_count_o                 - current run cycle
//                dump_*                        - dump beat valid/ready stream
//                run_done_o, timeout_o         - completion status
//  Revision    : 1.0 - initial release
// ============================================================================
module cardinal_run_monitor
    import cardinal_pkg::*;
#(
    parameter int unsigned             NUM_NODES      = 4,
    parameter int unsigned             INSTR_WIDTH    = 32,
    parameter logic [INSTR_WIDTH-1:0]  HALT_INSTR     = INSTR_WIDTH'(HALT_INSTR_DEFAULT),
    parameter int unsigned             CYC_WIDTH      = 32,
    parameter int unsigned             FLUSH_CYCLES   = 5,
    parameter int unsigned             DUMP_DEPTH     = 128,
    parameter int unsigned             TIMEOUT_CYCLES = 500
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic                                 run_start_i,
    input  logic [NUM_NODES-1:0]                 node_fetch_en_i,
    input  logic [NUM_NODES*INSTR_WIDTH-1:0]     node_instr_i,
    output logic [NUM_NODES-1:0]                 node_halted_o,
    output logic [NUM_NODES*CYC_WIDTH-1:0]       node_cycles_o,
    output logic [CYC_WIDTH-1:0]                 cycle_count_o,
    output logic                                 dump_valid_o,
    input  logic                                 dump_ready_i,
    output logic [idx_width(NUM_NODES)-1:0]      dump_node_o,
    output logic [idx_width(DUMP_DEPTH)-1:0]     dump_addr_o,
    output logic                                 dump_last_o,
    output logic                                 run_done_o,
    output logic                                 timeout_o
);

    localparam int unsigned NODE_W  = idx_width(NUM_NODES);
    localparam int unsigned ADDR_W  = idx_width(DUMP_DEPTH);
    localparam int unsigned FLUSH_W = idx_width(FLUSH_CYCLES);

    localparam logic [CYC_WIDTH-1:0] C_TIMEOUT_LAST = CYC_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [FLUSH_W-1:0]   C_FLUSH_LOAD   = FLUSH_W'(FLUSH_CYCLES - 1);

    state_t                          state_q, state_d;
    logic [FLUSH_W-1:0]              flush_q, flush_d;
    logic [CYC_WIDTH-1:0]            cyc_q, cyc_d;
    logic [NUM_NODES-1:0]            halted_q, halted_d;
    logic [NUM_NODES*CYC_WIDTH-1:0]  cycles_q, cycles_d;
    logic                            timeout_q, timeout_d;

    logic [NUM_NODES-1:0]            w_new_halt;
    logic                            w_all_halt;
    logic                            w_dump_start;
    logic                            w_dump_done;

    // A node halts on its first qualified halt word of the run only.
    for (genvar gi = 0; gi < NUM_NODES; gi++) begin : g_halt
        assign w_new_halt[gi] = (state_q == ST_RUN) && node_fetch_en_i[gi]
                              && (node_instr_i[gi*INSTR_WIDTH +: INSTR_WIDTH] == HALT_INSTR)
                              && !halted_q[gi];
    end

    // Includes halts landing this cycle, so the last halt moves straight on.
    assign w_all_halt = &(halted_q | w_new_halt);

    always_comb begin
        state_d      = state_q;
        flush_d      = flush_q;
        cyc_d        = cyc_q;
        halted_d     = halted_q;
        cycles_d     = cycles_q;
        timeout_d    = timeout_q;
        w_dump_start = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (run_start_i) begin
                    state_d   = ST_RUN;
                    cyc_d     = '0;
                    halted_d  = '0;
                    cycles_d  = '0;
                    timeout_d = 1'b0;
                end
            end
            ST_RUN: begin
                halted_d = halted_q | w_new_halt;
                for (int i = 0; i < int'(NUM_NODES); i++) begin
                    if (w_new_halt[i]) begin
                        cycles_d[i*CYC_WIDTH +: CYC_WIDTH] = cyc_q;
                    end
                end
                // Halt has priority over a timeout in the same cycle. The
                // count only advances while the run continues, so the value
                // at exit is the cycle on which the run ended.
                if (w_all_halt) begin
                    state_d = ST_FLUSH;
                    flush_d = C_FLUSH_LOAD;
                end else if (cyc_q == C_TIMEOUT_LAST) begin
                    state_d   = ST_DONE;
                    timeout_d = 1'b1;
                end else if (cyc_q != '1) begin
                    cyc_d = cyc_q + CYC_WIDTH'(1);
                end
            end
            ST_FLUSH: begin
                if (flush_q == '0) begin
                    state_d      = ST_DUMP;
                    w_dump_start = 1'b1;
                end else begin
                    flush_d = flush_q - FLUSH_W'(1);
                end
            end
            ST_DUMP: begin
                if (w_dump_done) begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            flush_q   <= '0;
            cyc_q     <= '0;
            halted_q  <= '0;
            cycles_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            flush_q   <= flush_d;
            cyc_q     <= cyc_d;
            halted_q  <= halted_d;
            cycles_q  <= cycles_d;
            timeout_q <= timeout_d;
        end
    end

    cardinal_dump_seq #(
        .NUM_NODES  (NUM_NODES),
        .DUMP_DEPTH (DUMP_DEPTH),
        .NODE_W     (NODE_W),
        .ADDR_W     (ADDR_W)
    ) u_dump_seq (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .start_i (w_dump_start),
        .ready_i (dump_ready_i),
        .valid_o (dump_valid_o),
        .node_o  (dump_node_o),
        .addr_o  (dump_addr_o),
        .last_o  (dump_last_o),
        .done_o  (w_dump_done)
    );

    assign node_halted_o = halted_q;
    assign node_cycles_o = cycles_q;
    assign cycle_count_o = cyc_q;
    assign run_done_o    = (state_q == ST_DONE);
    assign timeout_o     = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_cardinal_run_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cardinal_run_monitor
//  Description : Directed bench for cardinal_run_monitor (2 nodes, depth 4,
//                timeout 20) with a phase/beat-index reference model and
//                hand-computed expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cardinal_run_monitor;

    localparam int NN = 2;
    localparam int IW = 32;
    localparam int CW = 32;
    localparam int FL = 5;
    localparam int DD = 4;
    localparam int TO = 20;
    localparam int NW = 1;
    localparam int AW = 2;
    localparam logic [IW-1:0] HALT = 32'h0000_0000;
    localparam logic [IW-1:0] NOP  = 32'h0000_0013;

    localparam int P_IDLE = 0, P_RUN = 1, P_FLUSH = 2, P_DUMP = 3, P_DONE = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              run_start = 1'b0;
    logic              ready = 1'b0;
    logic [NN-1:0]     fetch_en = '0;
    logic [NN*IW-1:0]  instr = {NN{NOP}};

    logic [NN-1:0]     halted;
    logic [NN*CW-1:0]  node_cycles;
    logic [CW-1:0]     cycle_count;
    logic              dump_valid;
    logic [NW-1:0]     dump_node;
    logic [AW-1:0]     dump_addr;
    logic              dump_last;
    logic              run_done;
    logic              timeout;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    cardinal_run_monitor #(
        .NUM_NODES      (NN),
        .INSTR_WIDTH    (IW),
        .HALT_INSTR     (HALT),
        .CYC_WIDTH      (CW),
        .FLUSH_CYCLES   (FL),
        .DUMP_DEPTH     (DD),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .run_start_i     (run_start),
        .node_fetch_en_i (fetch_en),
        .node_instr_i    (instr),
        .node_halted_o   (halted),
        .node_cycles_o   (node_cycles),
        .cycle_count_o   (cycle_count),
        .dump_valid_o    (dump_valid),
        .dump_ready_i    (ready),
        .dump_node_o     (dump_node),
        .dump_addr_o     (dump_addr),
        .dump_last_o     (dump_last),
        .run_done_o      (run_done),
        .timeout_o       (timeout)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int              m_phase = P_IDLE;
    logic [CW-1:0]   m_cycle = '0;
    logic [NN-1:0]   m_halted = '0;
    logic [CW-1:0]   m_cyc [NN];
    int              m_flush_left = 0;
    int              m_beat = 0;
    logic            m_timeout = 1'b0;

    task automatic model_clear();
        m_cycle   = '0;
        m_halted  = '0;
        m_timeout = 1'b0;
        m_beat    = 0;
        for (int i = 0; i < NN; i++) m_cyc[i] = '0;
    endtask

    task automatic model_step();
        if (!rst_n) begin
            m_phase = P_IDLE;
            m_flush_left = 0;
            model_clear();
            return;
        end
        case (m_phase)
            P_IDLE, P_DONE: begin
                if (run_start) begin
                    m_phase = P_RUN;
                    model_clear();
                end
            end
            P_RUN: begin
                for (int i = 0; i < NN; i++) begin
                    if (fetch_en[i] && instr[i*IW +: IW] == HALT && !m_halted[i]) begin
                        m_halted[i] = 1'b1;
                        m_cyc[i]    = m_cycle;
                    end
                end
                if (&m_halted) begin
                    m_phase = P_FLUSH;
                    m_flush_left = FL;
                end else if (m_cycle == CW'(TO - 1)) begin
                    m_phase = P_DONE;
                    m_timeout = 1'b1;
                end else if (m_cycle != '1) begin
                    m_cycle = m_cycle + 1;
                end
            end
            P_FLUSH: begin
                m_flush_left--;
                if (m_flush_left == 0) begin
                    m_phase = P_DUMP;
                    m_beat = 0;
                end
            end
            P_DUMP: begin
                if (ready) begin
                    m_beat++;
                    if (m_beat == NN*DD) m_phase = P_DONE;
                end
            end
            default: m_phase = P_IDLE;
        endcase
    endtask

    initial begin
        for (int i = 0; i < NN; i++) m_cyc[i] = '0;
        forever begin
            @(posedge clk or negedge rst_n);
            model_step();
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        logic [NN*CW-1:0] exp_cycles;
        logic             exp_valid;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                for (int i = 0; i < NN; i++) exp_cycles[i*CW +: CW] = m_cyc[i];
                exp_valid = (m_phase == P_DUMP);
                chk("m_halted",  halted, m_halted);
                chk("m_cycles",  node_cycles, exp_cycles);
                chk("m_count",   cycle_count, m_cycle);
                chk("m_valid",   dump_valid, exp_valid);
                chk("m_done",    run_done, m_phase == P_DONE);
                chk("m_timeout", timeout, m_timeout);
                chk("m_last",    dump_last, exp_valid && (m_beat == NN*DD - 1));
                if (exp_valid) begin
                    chk("m_node", dump_node, m_beat / DD);
                    chk("m_addr", dump_addr, m_beat % DD);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_fetch(input int n, input logic en, input logic [IW-1:0] ins);
        fetch_en[n] = en;
        instr[n*IW +: IW] = ins;
    endtask

    task automatic fetch_nop();
        fetch_en = '1;
        instr = {NN{NOP}};
    endtask

    task automatic start_run();
        @(negedge clk);
        run_start = 1'b1;
        @(negedge clk);
        run_start = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_flags"}, {dump_valid, dump_last, run_done, timeout, halted}, '0);
        chk({tag, "_count"}, cycle_count, '0);
        chk({tag, "_cycles"}, node_cycles, '0);
        chk({tag, "_ptr"}, {dump_node, dump_addr}, '0);
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (!run_done && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_done_reached"}, run_done, 1'b1);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int k;
        int p;
        int hs;
        int first_valid;
        int k_last;
        int k_done;
        bit saw_valid;
        bit rp [4];
        rp = '{1'b1, 1'b0, 1'b0, 1'b1};

        // Reset state
        fetch_nop();
        @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);
        chk_all_zero("idle");

        // Staggered halt with Ready backpressure during the dump
        start_run();
        chk("stag_c0_count", cycle_count, 0);
        chk("stag_c0_halted", halted, 0);
        for (k = 0; k <= 12; k++) begin
            if (k == 5) chk("en0_halt_ignored", halted, 2'b00);
            if (k == 8) chk("node0_only", halted, 2'b01);
            fetch_nop();
            if (k == 4) set_fetch(1, 1'b0, HALT);
            if (k == 7 || k == 9) set_fetch(0, 1'b1, HALT);
            if (k == 12) set_fetch(1, 1'b1, HALT);
            @(negedge clk);
        end
        fetch_nop();
        chk("stag_cycles", node_cycles, {32'd12, 32'd7});
        chk("flush_count_hold", cycle_count, 12);

        ready = 1'b1;
        p = 0; hs = 0; first_valid = -1; k_last = -1; k_done = -1;
        while (!run_done && k < 80) begin
            if (dump_valid) begin
                if (first_valid < 0) begin
                    first_valid = k;
                    chk("first_beat", {dump_node, dump_addr}, 0);
                end
                ready = rp[p % 4];
                p++;
                if (ready) begin
                    chk("bp_node", dump_node, hs / DD);
                    chk("bp_addr", dump_addr, hs % DD);
                    chk("bp_last", dump_last, hs == NN*DD - 1);
                    hs++;
                    k_last = k;
                end
            end else begin
                ready = 1'b1;
            end
            @(negedge clk);
            k++;
        end
        k_done = k;
        chk("first_valid_cycle", first_valid, 18);
        chk("handshakes", hs, 8);
        chk("last_hs_cycle", k_last, 33);
        chk("done_cycle", k_done, 34);
        chk("done_no_valid", dump_valid, 1'b0);
        chk("done_hold_cycles", node_cycles, {32'd12, 32'd7});

        // Simultaneous halt, restart from DONE
        ready = 1'b1;
        start_run();
        chk("rst1_halted", halted, 0);
        chk("rst1_cycles", node_cycles, 0);
        chk("rst1_count", cycle_count, 0);
        for (k = 0; k <= 3; k++) begin
            fetch_nop();
            if (k == 3) begin
                set_fetch(0, 1'b1, HALT);
                set_fetch(1, 1'b1, HALT);
            end
            @(negedge clk);
        end
        fetch_nop();
        set_fetch(0, 1'b1, HALT);
        chk("sim_cycles", node_cycles, {32'd3, 32'd3});
        chk("sim_halted", halted, 2'b11);
        @(negedge clk);
        chk("sim_flush_hold", cycle_count, 3);
        chk("sim_cycles_hold", node_cycles, {32'd3, 32'd3});
        fetch_nop();
        wait_done("sim", 40);

        // Timeout: node1 never halts
        start_run();
        chk("rst2_cycles", node_cycles, 0);
        saw_valid = 1'b0;
        for (k = 0; k <= 19; k++) begin
            fetch_nop();
            if (k == 2) set_fetch(0, 1'b1, HALT);
            if (dump_valid) saw_valid = 1'b1;
            @(negedge clk);
        end
        chk("to_done", run_done, 1'b1);
        chk("to_flag", timeout, 1'b1);
        chk("to_count", cycle_count, 19);
        chk("to_halted", halted, 2'b01);
        for (int j = 0; j < 3; j++) begin
            if (dump_valid) saw_valid = 1'b1;
            @(negedge clk);
        end
        chk("to_no_dump", saw_valid, 1'b0);

        // Halt and timeout on the same cycle: halt wins
        start_run();
        chk("rst3_timeout", timeout, 1'b0);
        chk("rst3_halted", halted, 0);
        for (k = 0; k <= 19; k++) begin
            fetch_nop();
            if (k == 5) set_fetch(0, 1'b1, HALT);
            if (k == 19) set_fetch(1, 1'b1, HALT);
            @(negedge clk);
        end
        fetch_nop();
        chk("tie_timeout", timeout, 1'b0);
        chk("tie_done", run_done, 1'b0);
        chk("tie_count", cycle_count, 19);
        chk("tie_cycles", node_cycles, {32'd19, 32'd5});

        // Mid-dump reset at beat 3
        k = 0;
        while (!(dump_valid && dump_node == 0 && dump_addr == 3) && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("reach_beat3", {dump_valid, dump_addr}, {1'b1, 2'd3});
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk_all_zero("async_rst");
        @(negedge clk);
        run_start = 1'b1;
        @(negedge clk);
        run_start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk_all_zero("rst_held");
        rst_n = 1'b1;
        @(negedge clk);
        chk_all_zero("post_rst");

        start_run();
        set_fetch(0, 1'b1, HALT);
        set_fetch(1, 1'b1, HALT);
        @(negedge clk);
        fetch_nop();
        k = 0;
        while (!dump_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("new_dump_valid", dump_valid, 1'b1);
        chk("new_dump_start", {dump_node, dump_addr}, 0);
        wait_done("final", 40);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
